// File: rtl/uart_tx_retry.sv
// UART transmitter that re-sends the held word when the receiver flags an error during the frame or guard window.
// Latency: start bit on the cycle after accept; DoneTx (F+GUARD_BITS)*CLKS_PER_BIT cycles after accept, plus that much again per retry.
// Backpressure: NewData is accepted only while idle (Busy=0, which includes the DoneTx cycle); requests while busy are dropped.
module uart_tx_retry #(
    parameter int DATA_WIDTH   = 32,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int GUARD_BITS   = 2,
    parameter int CLKS_PER_BIT = 1,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  CLK_Baudin,
    input  logic                  RstTx_n,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  NewData,
    input  logic                  Flag_in,
    output logic                  TransmittedSerialData,
    output logic                  DoneTx,
    output logic                  Busy,
    output logic                  RetryErr,
    output logic [3:0]            RetryCnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GUARD
    } state_t;

    localparam int          CW       = $clog2(CLKS_PER_BIT + 1);
    localparam int          BW       = 7;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic        HAS_PAR  = (PARITY_MODE != 0);
    localparam logic        ODD_PAR  = (PARITY_MODE == 2);

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         cyc_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  retry_req_q;
    logic [3:0]            retry_cnt_q;
    logic                  done_q;
    logic                  err_q;

    logic bit_tick;
    logic last_bit;
    logic accept;
    logic retry_pend;
    logic retry_go;
    logic finish;
    logic par_bit;

    assign bit_tick   = (cyc_q == CYC_LAST);
    assign accept     = (state_q == S_IDLE) && NewData;
    // A flag seen on the final guard edge must still count, so merge it with the sticky latch.
    assign retry_pend = retry_req_q | Flag_in;
    assign par_bit    = ODD_PAR ? ~(^hold_q) : (^hold_q);

    always_ff @(posedge CLK_Baudin or negedge RstTx_n) begin
        if (!RstTx_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_bit = 1'b0;
        retry_go = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (NewData) state_d = S_START;
            end
            S_START: begin
                last_bit = 1'b1;
                if (bit_tick) state_d = S_DATA;
            end
            S_DATA: begin
                last_bit = (bit_q == BW'(DATA_WIDTH - 1));
                if (bit_tick && last_bit) state_d = HAS_PAR ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                last_bit = 1'b1;
                if (bit_tick) state_d = S_STOP;
            end
            S_STOP: begin
                last_bit = (bit_q == BW'(STOP_BITS - 1));
                if (bit_tick && last_bit) state_d = S_GUARD;
            end
            S_GUARD: begin
                last_bit = (bit_q == BW'(GUARD_BITS - 1));
                if (bit_tick && last_bit) begin
                    if (retry_pend && (retry_cnt_q < 4'(MAX_RETRY))) begin
                        state_d  = S_START;
                        retry_go = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        finish  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        TransmittedSerialData = 1'b1;
        Busy                  = (state_q != S_IDLE);
        case (state_q)
            S_START:  TransmittedSerialData = 1'b0;
            S_DATA:   TransmittedSerialData = shift_q[0];
            S_PARITY: TransmittedSerialData = par_bit;
            default:  TransmittedSerialData = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_Baudin or negedge RstTx_n) begin
        if (!RstTx_n) begin
            cyc_q       <= '0;
            bit_q       <= '0;
            hold_q      <= '0;
            shift_q     <= '0;
            retry_req_q <= 1'b0;
            retry_cnt_q <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= finish;
            err_q  <= finish & retry_pend;

            if (accept) begin
                hold_q      <= DataIn;
                retry_cnt_q <= 4'd0;
                retry_req_q <= 1'b0;
            end else begin
                if (retry_go) retry_cnt_q <= retry_cnt_q + 4'd1;
                if (retry_go || finish) retry_req_q <= 1'b0;
                else if ((state_q != S_IDLE) && Flag_in) retry_req_q <= 1'b1;
            end

            if (state_q == S_IDLE) begin
                cyc_q <= '0;
                bit_q <= '0;
            end else if (bit_tick) begin
                cyc_q <= '0;
                bit_q <= last_bit ? '0 : bit_q + BW'(1);
            end else begin
                cyc_q <= cyc_q + CW'(1);
            end

            // Each attempt reloads from the hold buffer so retries resend the original word.
            if ((state_q == S_START) && bit_tick) shift_q <= hold_q;
            else if ((state_q == S_DATA) && bit_tick) shift_q <= shift_q >> 1;
        end
    end

    assign DoneTx   = done_q;
    assign RetryErr = err_q;
    assign RetryCnt = retry_cnt_q;

endmodule

// File: tb/tb_uart_tx_retry.sv
// Scoreboard bench for uart_tx_retry: stimulus queues expected frames, a negedge monitor checks each DoneTx.
module tb_uart_tx_retry;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] din1, din2;
    logic        nd1, nd2, flag1, flag2;
    logic        tx1, done1, busy1, err1;
    logic        tx2, done2, busy2, err2;
    logic [3:0]  cnt1, cnt2;

    uart_tx_retry u_dut1 (
        .CLK_Baudin(clk), .RstTx_n(rst_n), .DataIn(din1), .NewData(nd1), .Flag_in(flag1),
        .TransmittedSerialData(tx1), .DoneTx(done1), .Busy(busy1), .RetryErr(err1), .RetryCnt(cnt1)
    );

    uart_tx_retry #(
        .DATA_WIDTH(32), .PARITY_MODE(2), .STOP_BITS(2), .GUARD_BITS(2), .CLKS_PER_BIT(4), .MAX_RETRY(3)
    ) u_dut2 (
        .CLK_Baudin(clk), .RstTx_n(rst_n), .DataIn(din2), .NewData(nd2), .Flag_in(flag2),
        .TransmittedSerialData(tx2), .DoneTx(done2), .Busy(busy2), .RetryErr(err2), .RetryCnt(cnt2)
    );

    typedef struct {
        logic [255:0] wave;
        int           len;
        int           lat;
        logic [3:0]   cnt;
        logic         err;
        time          t_acc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int n_chk  = 0;
    int n_pass = 0;
    logic [255:0] hist1 = '1;
    logic [255:0] hist2 = '1;
    exp_t e1, e2;
    int lat1, lat2;
    logic [255:0] mask1, mask2;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected line samples, first cycle after accept in the highest used bit.
    function automatic exp_t mk_exp(input logic [31:0] d, input logic has_par, input logic par,
                                    input int sb, input int gb, input int cpb, input int attempts,
                                    input logic [3:0] cnt, input logic err, input int lat, input time t);
        exp_t e;
        logic [255:0] seq;
        int k;
        k   = 0;
        seq = '1;
        for (int a = 0; a < attempts; a++) begin
            for (int b = 0; b < 1 + 32 + (has_par ? 1 : 0) + sb + gb; b++) begin
                logic v;
                if (b == 0) v = 1'b0;
                else if (b <= 32) v = d[b-1];
                else if (has_par && b == 33) v = par;
                else v = 1'b1;
                for (int c = 0; c < cpb; c++) begin
                    seq[k] = v;
                    k++;
                end
            end
        end
        e.wave = '0;
        for (int j = 0; j < k; j++) e.wave[k-1-j] = seq[j];
        e.len   = k;
        e.lat   = lat;
        e.cnt   = cnt;
        e.err   = err;
        e.t_acc = t;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                chk("dut1_spurious_done_queue", 256'(q1.size()), 256'(1));
            end else begin
                e1 = q1.pop_front();
                lat1 = int'(($time - 5 - e1.t_acc) / 10);
                mask1 = {256{1'b1}} >> (256 - e1.len);
                chk("dut1_latency", 256'(lat1), 256'(e1.lat));
                chk("dut1_line", hist1 & mask1, e1.wave);
                chk("dut1_retry_cnt", 256'(cnt1), 256'(e1.cnt));
                chk("dut1_retry_err", 256'(err1), 256'(e1.err));
                chk("dut1_busy_at_done", 256'(busy1), 256'(0));
            end
        end else if (err1) begin
            chk("dut1_err_without_done", 256'(err1), 256'(0));
        end
        hist1 = {hist1[254:0], tx1};
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                chk("dut2_spurious_done_queue", 256'(q2.size()), 256'(1));
            end else begin
                e2 = q2.pop_front();
                lat2 = int'(($time - 5 - e2.t_acc) / 10);
                mask2 = {256{1'b1}} >> (256 - e2.len);
                chk("dut2_latency", 256'(lat2), 256'(e2.lat));
                chk("dut2_line", hist2 & mask2, e2.wave);
                chk("dut2_retry_cnt", 256'(cnt2), 256'(e2.cnt));
                chk("dut2_retry_err", 256'(err2), 256'(e2.err));
            end
        end else if (err2) begin
            chk("dut2_err_without_done", 256'(err2), 256'(0));
        end
        hist2 = {hist2[254:0], tx2};
    end

    task automatic send1(input logic [31:0] d, output time t);
        @(negedge clk);
        din1 = d;
        nd1  = 1'b1;
        @(posedge clk);
        t = $time;
        #1;
        nd1  = 1'b0;
        din1 = ~d;
    endtask

    task automatic send2(input logic [31:0] d, output time t);
        @(negedge clk);
        din2 = d;
        nd2  = 1'b1;
        @(posedge clk);
        t = $time;
        #1;
        nd2  = 1'b0;
        din2 = ~d;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((q1.size() != 0 || q2.size() != 0) && i < budget) begin
            @(posedge clk);
            i++;
        end
        if (i >= budget) chk("drain_timeout", 256'(q1.size() + q2.size()), 256'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        time t, t2;
        rst_n = 1'b0;
        nd1 = 1'b0; nd2 = 1'b0; flag1 = 1'b0; flag2 = 1'b0;
        din1 = '0;  din2 = '0;
        #12;
        chk("rst_line", 256'(tx1), 256'(1));
        chk("rst_done", 256'(done1), 256'(0));
        chk("rst_busy", 256'(busy1), 256'(0));
        chk("rst_err", 256'(err1), 256'(0));
        chk("rst_cnt", 256'(cnt1), 256'(0));
        chk("rst_line2", 256'(tx2), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain word: parity of A5A5A5A5 is 0, done at 37.
        send1(32'hA5A5A5A5, t);
        q1.push_back(mk_exp(32'hA5A5A5A5, 1'b1, 1'b0, 1, 2, 1, 1, 4'd0, 1'b0, 37, t));
        chk("t1_busy_after_accept", 256'(busy1), 256'(1));
        chk("t1_start_bit", 256'(tx1), 256'(0));
        drain(200);

        // One-cycle flag during the parity bit (cycle 33): one retry, done at 74.
        send1(32'h12345678, t);
        q1.push_back(mk_exp(32'h12345678, 1'b1, 1'b1, 1, 2, 1, 2, 4'd1, 1'b0, 74, t));
        repeat (33) @(posedge clk);
        @(negedge clk);
        flag1 = 1'b1;
        @(negedge clk);
        flag1 = 1'b0;
        drain(200);
        repeat (5) @(negedge clk);
        chk("t2_cnt_hold_idle", 256'(cnt1), 256'(1));

        // Flag held for the whole transfer: 4 attempts, error at 148.
        flag1 = 1'b1;
        send1(32'h000000FF, t);
        q1.push_back(mk_exp(32'h000000FF, 1'b1, 1'b0, 1, 2, 1, 4, 4'd3, 1'b1, 148, t));
        drain(400);
        flag1 = 1'b0;

        // Odd parity, 2 stop bits, 4 clocks/bit: done at 152.
        send2(32'hDEADBEEF, t);
        q2.push_back(mk_exp(32'hDEADBEEF, 1'b1, 1'b1, 2, 2, 4, 1, 4'd0, 1'b0, 152, t));
        drain(400);

        // Mid-frame request dropped; request in the DoneTx cycle accepted back-to-back.
        send1(32'h0F0F0F0F, t);
        q1.push_back(mk_exp(32'h0F0F0F0F, 1'b1, 1'b0, 1, 2, 1, 1, 4'd0, 1'b0, 37, t));
        repeat (10) @(posedge clk);
        @(negedge clk);
        nd1  = 1'b1;
        din1 = 32'hFFFF0000;
        @(negedge clk);
        nd1  = 1'b0;
        repeat (26) @(posedge clk);
        @(negedge clk);
        chk("t5_done_cycle", 256'(done1), 256'(1));
        chk("t5_busy_in_done_cycle", 256'(busy1), 256'(0));
        nd1  = 1'b1;
        din1 = 32'h3C3C3C3C;
        @(posedge clk);
        t2 = $time;
        #1;
        nd1  = 1'b0;
        din1 = 32'h0;
        q1.push_back(mk_exp(32'h3C3C3C3C, 1'b1, 1'b0, 1, 2, 1, 1, 4'd0, 1'b0, 37, t2));
        chk("t5_next_start_bit", 256'(tx1), 256'(0));
        drain(200);

        // Reset during data bit 10 (a 0 bit of 1234F00F).
        send1(32'h1234F00F, t);
        repeat (11) @(posedge clk);
        #3;
        chk("t6_line_before_reset", 256'(tx1), 256'(0));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_line", 256'(tx1), 256'(1));
        chk("t6_rst_busy", 256'(busy1), 256'(0));
        chk("t6_rst_done", 256'(done1), 256'(0));
        chk("t6_rst_err", 256'(err1), 256'(0));
        chk("t6_rst_cnt", 256'(cnt1), 256'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        send1(32'h80000001, t);
        q1.push_back(mk_exp(32'h80000001, 1'b1, 1'b0, 1, 2, 1, 1, 4'd0, 1'b0, 37, t));
        drain(200);

        repeat (3) @(negedge clk);
        chk("end_queues_empty", 256'(q1.size() + q2.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
